// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the divider controller
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int          DIV_LATENCY_DEFAULT = 4;
    localparam logic [31:0] DIV_ZERO_QUOTIENT   = 32'hFFFF_FFFF;

endpackage

// File: rtl/twos_negate_32.sv
// rtl/twos_negate_32.sv - conditional 32-bit two's-complement negate
module twos_negate_32 (
    input  logic        neg_i,
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    assign y_o = neg_i ? (~x_i + 32'd1) : x_i;

endmodule

// File: rtl/divider_controller_32.sv
// rtl/divider_controller_32.sv - start/busy/done sequencer with sign fix-up around divider_32
module divider_controller_32
    import div_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_start,
    input  logic        in_signed,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_quotient,
    output logic [31:0] out_remainder,
    output logic        out_div_by_zero,
    output logic [31:0] out_div_dividend,
    output logic [31:0] out_div_divisor,
    input  logic [31:0] in_div_quotient,
    input  logic [31:0] in_div_remainder
);

    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic [31:0]      raw_quot_q;
    logic [31:0]      raw_rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [31:0]      quot_q;
    logic [31:0]      rem_q;
    logic [31:0]      div_dividend_q;
    logic [31:0]      div_divisor_q;

    logic [31:0]      dividend_mag;
    logic [31:0]      divisor_mag;
    logic [31:0]      quot_fix;
    logic [31:0]      rem_fix;

    // abs(0x80000000) stays 0x80000000, which the divider treats as an unsigned magnitude
    twos_negate_32 u_abs_dividend (
        .neg_i (in_signed & in_dividend[31]),
        .x_i   (in_dividend),
        .y_o   (dividend_mag)
    );

    twos_negate_32 u_abs_divisor (
        .neg_i (in_signed & in_divisor[31]),
        .x_i   (in_divisor),
        .y_o   (divisor_mag)
    );

    twos_negate_32 u_fix_quot (
        .neg_i (neg_quot_q),
        .x_i   (raw_quot_q),
        .y_o   (quot_fix)
    );

    twos_negate_32 u_fix_rem (
        .neg_i (neg_rem_q),
        .x_i   (raw_rem_q),
        .y_o   (rem_fix)
    );

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            neg_quot_q     <= 1'b0;
            neg_rem_q      <= 1'b0;
            raw_quot_q     <= '0;
            raw_rem_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            dbz_q          <= 1'b0;
            quot_q         <= '0;
            rem_q          <= '0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_start) begin
                        div_dividend_q <= dividend_mag;
                        div_divisor_q  <= divisor_mag;
                        neg_quot_q     <= in_signed & (in_dividend[31] ^ in_divisor[31]);
                        neg_rem_q      <= in_signed & in_dividend[31];
                        busy_q         <= 1'b1;
                        cnt_q          <= '0;
                        if (in_divisor == '0) begin
                            quot_q  <= DIV_ZERO_QUOTIENT;
                            rem_q   <= in_dividend;
                            dbz_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == CNT_W'(DIV_LATENCY)) begin
                        raw_quot_q <= in_div_quotient;
                        raw_rem_q  <= in_div_remainder;
                        state_q    <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quot_q  <= quot_fix;
                    rem_q   <= rem_fix;
                    dbz_q   <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_busy         = busy_q;
    assign out_done         = done_q;
    assign out_quotient     = quot_q;
    assign out_remainder    = rem_q;
    assign out_div_by_zero  = dbz_q;
    assign out_div_dividend = div_dividend_q;
    assign out_div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_divider_controller_32.sv
// tb/tb_divider_controller_32.sv - self-checking bench for divider_controller_32
module tb_divider_controller_32;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_start = 1'b0;
    logic        in_signed = 1'b0;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor = '0;
    logic        out_busy;
    logic        out_done;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_div_by_zero;
    logic [31:0] out_div_dividend;
    logic [31:0] out_div_divisor;
    logic [31:0] in_div_quotient;
    logic [31:0] in_div_remainder;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    divider_controller_32 #(.DIV_LATENCY(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_start         (in_start),
        .in_signed        (in_signed),
        .in_dividend      (in_dividend),
        .in_divisor       (in_divisor),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_quotient     (out_quotient),
        .out_remainder    (out_remainder),
        .out_div_by_zero  (out_div_by_zero),
        .out_div_dividend (out_div_dividend),
        .out_div_divisor  (out_div_divisor),
        .in_div_quotient  (in_div_quotient),
        .in_div_remainder (in_div_remainder)
    );

    // Stand-in for divider_32: the operand edge counts as the first of LAT edges.
    logic [31:0] pipe_q [LAT-1];
    logic [31:0] pipe_r [LAT-1];

    always @(posedge clk) begin
        pipe_q[0] <= (out_div_divisor == '0) ? 32'hFFFF_FFFF : out_div_dividend / out_div_divisor;
        pipe_r[0] <= (out_div_divisor == '0) ? out_div_dividend : out_div_dividend % out_div_divisor;
        for (int i = 1; i < LAT - 1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
            pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign in_div_quotient  = pipe_q[LAT-2];
    assign in_div_remainder = pipe_r[LAT-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] magnitude(input logic s, input logic [31:0] x);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == '0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            dz = 1'b0;
        end
    endfunction

    // Reference model: timing and arithmetic taken from the request/response rules directly.
    longint      cyc = 0;
    longint      res_edge = 0;
    longint      done_edge = 0;
    bit          pending = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] p_q = '0;
    logic [31:0] p_r = '0;
    logic        p_dz = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            pending = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_dz    = 1'b0;
            m_q     = '0;
            m_r     = '0;
            m_a     = '0;
            m_b     = '0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (pending && cyc == res_edge) begin
                m_q  = p_q;
                m_r  = p_r;
                m_dz = p_dz;
            end
            if (pending && cyc == done_edge) begin
                m_done  = 1'b1;
                pending = 1'b0;
            end else if (!pending && in_start) begin
                ref_div(in_signed, in_dividend, in_divisor, p_q, p_r, p_dz);
                m_a     = magnitude(in_signed, in_dividend);
                m_b     = magnitude(in_signed, in_divisor);
                pending = 1'b1;
                if (p_dz) begin
                    m_q       = p_q;
                    m_r       = p_r;
                    m_dz      = 1'b1;
                    res_edge  = 0;
                    done_edge = cyc + 1;
                end else begin
                    res_edge  = cyc + LAT + 1;
                    done_edge = cyc + LAT + 2;
                end
            end
            m_busy = pending;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cyc_busy", 32'(out_busy), 32'(m_busy));
            check("cyc_done", 32'(out_done), 32'(m_done));
            check("cyc_quotient", out_quotient, m_q);
            check("cyc_remainder", out_remainder, m_r);
            check("cyc_div_by_zero", 32'(out_div_by_zero), 32'(m_dz));
            check("cyc_div_dividend", out_div_dividend, m_a);
            check("cyc_div_divisor", out_div_divisor, m_b);
        end
    end

    task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int glitch_at);
        int n;
        int busy_n;
        bit seen;
        in_signed   = s;
        in_dividend = a;
        in_divisor  = b;
        in_start    = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        n        = 0;
        busy_n   = out_busy ? 1 : 0;
        seen     = 1'b0;
        while (!seen && n < 40) begin
            if (n == glitch_at) begin
                in_start    = 1'b1;
                in_signed   = ~s;
                in_dividend = 32'd5;
                in_divisor  = 32'd5;
            end else begin
                in_start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (out_done) seen = 1'b1;
            else if (out_busy) busy_n++;
        end
        in_start = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, n);
        end else begin
            check({name, "_latency"}, 32'(n), edz ? 32'd1 : 32'(LAT + 2));
            check({name, "_busy_cycles"}, 32'(busy_n), edz ? 32'd1 : 32'(LAT + 2));
            check({name, "_q"}, out_quotient, eq);
            check({name, "_r"}, out_remainder, er);
            check({name, "_dz"}, 32'(out_div_by_zero), 32'(edz));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first;
        int second;
        int dones;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_q", out_quotient, 32'd0);
        check("rst_div_dividend", out_div_dividend, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        run_op("u30_4", 1'b0, 32'd30, 32'd4, 32'd7, 32'd2, 1'b0, -1);
        run_op("s10_m3", 1'b1, 32'd10, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd1, 1'b0, -1);
        run_op("sm500_3", 1'b1, 32'hFFFF_FE0C, 32'd3, 32'hFFFF_FF5A, 32'hFFFF_FFFE, 1'b0, -1);
        run_op("sm100_m9", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF7, 32'd11, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("dz1234", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, -1);
        run_op("u8_2", 1'b0, 32'd8, 32'd2, 32'd4, 32'd0, 1'b0, -1);
        run_op("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, -1);
        run_op("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, -1);
        run_op("dz_neg", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, -1);
        run_op("u_msb_3", 1'b0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, -1);
        run_op("glitch", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 2);
        check("glitch_div_dividend", out_div_dividend, 32'd100);

        // Start held high: second acceptance on the edge after the done pulse.
        in_signed   = 1'b0;
        in_dividend = 32'd30;
        in_divisor  = 32'd4;
        in_start    = 1'b1;
        n = 0;
        first = -1;
        second = -1;
        while (second < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (out_done) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        in_start = 1'b0;
        if (second < 0) begin
            checks++;
            failures++;
            $display("FAIL b2b_timeout: second done not seen, first=%0d", first);
        end else begin
            check("b2b_interval", 32'(second - first), 32'(LAT + 3));
        end
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        in_dividend = 32'd30;
        in_divisor  = 32'd4;
        in_start    = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(out_busy), 32'd0);
        check("arst_done", 32'(out_done), 32'd0);
        check("arst_q", out_quotient, 32'd0);
        check("arst_r", out_remainder, 32'd0);
        check("arst_dz", 32'(out_div_by_zero), 32'd0);
        check("arst_div_dividend", out_div_dividend, 32'd0);
        check("arst_div_divisor", out_div_divisor, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_done) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);
        run_op("post_rst_30_4", 1'b0, 32'd30, 32'd4, 32'd7, 32'd2, 1'b0, -1);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
